// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I datapath: ALU operations, immediate formats
// and result-select values driven by the external controller.
package riscv_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

endpackage

// File: rtl/data_path_reg_file.sv
// 32-entry register file with two combinational read ports and one write port;
// x0 reads as zero and ignores writes, and reset clears every entry.
module reg_file #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-write value; there is no write-to-read bypass.
    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/data_path.sv
// Single-cycle RV32I datapath: PC, next-PC logic, register file, immediate
// extender, ALU and result mux, steered entirely by an external controller.
module data_path
    import riscv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] readdata,
    input  logic            pcsrc,
    input  logic            alusrc,
    input  logic            regwrite,
    input  logic [1:0]      immsrc,
    input  logic [2:0]      alucontrol,
    input  logic [1:0]      memtoreg,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] aluresult,
    output logic [XLEN-1:0] writedata,
    output logic            zero
);

    logic [XLEN-1:0]        pcplus4;
    logic [XLEN-1:0]        pctarget;
    logic [XLEN-1:0]        immext;
    logic [XLEN-1:0]        rd1;
    logic [XLEN-1:0]        rd2;
    logic [XLEN-1:0]        result;
    logic signed [XLEN-1:0] src_a;
    logic signed [XLEN-1:0] src_b;
    logic                   unused_opcode;

    // The opcode field is decoded by the controller, not here.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        immext = '0;
        case (immsrc)
            IMM_I: immext = {{20{instr[31]}}, instr[31:20]};
            IMM_S: immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: immext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: immext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immext = '0;
        endcase
    end

    assign pcplus4  = pc + 32'd4;
    assign pctarget = pc + immext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pcsrc ? pctarget : pcplus4;
        end
    end

    reg_file #(
        .XLEN(XLEN)
    ) u_reg_file (
        .clk   (clk),
        .reset (reset),
        .we    (regwrite),
        .ra1   (instr[19:15]),
        .ra2   (instr[24:20]),
        .wa    (instr[11:7]),
        .wd    (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign src_a = rd1;
    assign src_b = alusrc ? immext : rd2;

    // Both operands are signed so SLT compares in two's complement.
    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ALU_AND: aluresult = src_a & src_b;
            ALU_OR:  aluresult = src_a | src_b;
            ALU_ADD: aluresult = src_a + src_b;
            ALU_XOR: aluresult = src_a ^ src_b;
            ALU_SUB: aluresult = src_a - src_b;
            ALU_SLT: aluresult = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

    always_comb begin
        result = aluresult;
        case (memtoreg)
            RES_ALU: result = aluresult;
            RES_MEM: result = readdata;
            RES_PC4: result = pcplus4;
            RES_IMM: result = immext;
            default: result = aluresult;
        endcase
    end

    assign writedata = rd2;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: expectations are queued as each instruction is
// applied and popped against the DUT outputs at the following falling edge.
module tb_data_path;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] readdata;
    logic        pcsrc;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  immsrc;
    logic [2:0]  alucontrol;
    logic [1:0]  memtoreg;
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic        zero;

    data_path #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .readdata   (readdata),
        .pcsrc      (pcsrc),
        .alusrc     (alusrc),
        .regwrite   (regwrite),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .memtoreg   (memtoreg),
        .pc         (pc),
        .aluresult  (aluresult),
        .writedata  (writedata),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    localparam int SEL_PC = 0;
    localparam int SEL_ALU = 1;
    localparam int SEL_WD = 2;
    localparam int SEL_ZERO = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] link;

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_PC:   return pc;
            SEL_ALU:  return aluresult;
            SEL_WD:   return writedata;
            default:  return {31'b0, zero};
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Compare queued expectations (plus the current pc), then commit one edge.
    task automatic cycle(input logic [31:0] nxt);
        expect_val("pc", SEL_PC, exp_pc);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        exp_pc = nxt;
    endtask

    task automatic set_ctl(input logic ps, input logic as, input logic rw,
                           input logic [1:0] is, input logic [2:0] ac, input logic [1:0] mr);
        pcsrc = ps; alusrc = as; regwrite = rw; immsrc = is; alucontrol = ac; memtoreg = mr;
    endtask

    initial begin
        reset = 1'b0;
        instr = 'x; readdata = 'x;
        pcsrc = 'x; alusrc = 'x; regwrite = 'x; immsrc = 'x; alucontrol = 'x; memtoreg = 'x;
        repeat (3) @(posedge clk);
        #1;
        instr = 32'h00100033;
        readdata = 32'h0;
        set_ctl(0, 0, 0, IMM_I, ALU_ADD, RES_ALU);
        expect_val("rst_pc", SEL_PC, 32'h0);
        expect_val("rst_wd", SEL_WD, 32'h0);
        @(negedge clk);
        drain();
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_pc = 32'd4;

        cycle(exp_pc + 4);

        set_ctl(0, 1, 1, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h0E800093; expect_val("addi_x1", SEL_ALU, 32'd232); cycle(exp_pc + 4);
        instr = 32'h3E800113; expect_val("addi_x2", SEL_ALU, 32'd1000); cycle(exp_pc + 4);

        set_ctl(0, 0, 1, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h001101B3;
        expect_val("add_x3", SEL_ALU, 32'h4D0);
        expect_val("add_wd", SEL_WD, 32'd232);
        cycle(exp_pc + 4);

        alucontrol = ALU_SUB;
        instr = 32'h40110233;
        expect_val("sub_x4", SEL_ALU, 32'h300);
        expect_val("sub_zero0", SEL_ZERO, 32'd0);
        cycle(exp_pc + 4);

        instr = 32'h401082B3;
        expect_val("sub_self", SEL_ALU, 32'd0);
        expect_val("sub_zero1", SEL_ZERO, 32'd1);
        cycle(exp_pc + 4);

        set_ctl(0, 1, 1, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h06400013; expect_val("addi_x0", SEL_ALU, 32'd100); cycle(exp_pc + 4);

        set_ctl(0, 0, 0, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00000333;
        expect_val("x0_alu", SEL_ALU, 32'd0);
        expect_val("x0_wd", SEL_WD, 32'd0);
        cycle(exp_pc + 4);

        alucontrol = ALU_OR;
        instr = 32'h0041E033;
        expect_val("or_x3x4", SEL_ALU, 32'h7D0);
        expect_val("x4_wd", SEL_WD, 32'd768);
        cycle(exp_pc + 4);

        instr = 32'h00118033;
        alucontrol = ALU_AND; expect_val("and", SEL_ALU, 32'h0C0); cycle(exp_pc + 4);
        alucontrol = ALU_OR;  expect_val("or", SEL_ALU, 32'h4F8); cycle(exp_pc + 4);
        alucontrol = ALU_XOR; expect_val("xor", SEL_ALU, 32'h438); cycle(exp_pc + 4);
        alucontrol = 3'b100;
        expect_val("op100", SEL_ALU, 32'd0);
        expect_val("op100_zero", SEL_ZERO, 32'd1);
        cycle(exp_pc + 4);
        alucontrol = 3'b101; expect_val("op101", SEL_ALU, 32'd0); cycle(exp_pc + 4);

        set_ctl(0, 1, 1, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'hFFC00393; expect_val("addi_neg", SEL_ALU, 32'hFFFF_FFFC); cycle(exp_pc + 4);

        set_ctl(0, 0, 0, IMM_I, ALU_SLT, RES_ALU);
        instr = 32'h00138033; expect_val("slt_neg_pos", SEL_ALU, 32'd1); cycle(exp_pc + 4);
        instr = 32'h00708033; expect_val("slt_pos_neg", SEL_ALU, 32'd0); cycle(exp_pc + 4);

        set_ctl(0, 1, 0, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00838013; expect_val("add_wrap", SEL_ALU, 32'd4); cycle(exp_pc + 4);

        set_ctl(1, 0, 0, IMM_B, ALU_SUB, RES_ALU);
        instr = 32'hFE000EE3; cycle(exp_pc - 4);
        set_ctl(1, 0, 0, IMM_J, ALU_ADD, RES_ALU);
        instr = 32'h0080006F; cycle(exp_pc + 8);

        set_ctl(0, 1, 1, IMM_I, ALU_ADD, RES_MEM);
        readdata = 32'hDEADBEEF;
        instr = 32'h00002403; expect_val("lw_addr", SEL_ALU, 32'd0); cycle(exp_pc + 4);
        set_ctl(0, 0, 0, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00800033; expect_val("lw_x8", SEL_WD, 32'hDEADBEEF); cycle(exp_pc + 4);

        set_ctl(1, 0, 1, IMM_J, ALU_ADD, RES_PC4);
        link = exp_pc + 4;
        instr = 32'h008004EF; cycle(exp_pc + 8);
        set_ctl(0, 0, 0, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00900033; expect_val("jal_link", SEL_WD, link); cycle(exp_pc + 4);

        set_ctl(0, 1, 1, IMM_I, ALU_AND, RES_IMM);
        instr = 32'h0FF00513; expect_val("imm_alu", SEL_ALU, 32'd0); cycle(exp_pc + 4);
        set_ctl(0, 0, 0, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00A00033; expect_val("imm_x10", SEL_WD, 32'd255); cycle(exp_pc + 4);

        set_ctl(0, 1, 0, IMM_S, ALU_ADD, RES_ALU);
        instr = 32'hFE112E23;
        expect_val("sw_addr", SEL_ALU, 32'd996);
        expect_val("sw_data", SEL_WD, 32'd232);
        cycle(exp_pc + 4);

        set_ctl(0, 1, 1, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00108093; expect_val("nobypass", SEL_ALU, 32'd233); cycle(exp_pc + 4);

        set_ctl(0, 0, 0, IMM_I, ALU_ADD, RES_ALU);
        instr = 32'h00100033;
        expect_val("x1_upd", SEL_WD, 32'd233);
        expect_val("pc_pre_rst", SEL_PC, exp_pc);
        @(negedge clk);
        drain();

        // Reset lands mid-cycle with a write pending; nothing may survive it.
        @(posedge clk);
        #3;
        regwrite = 1'b1;
        instr = 32'h00108093;
        reset = 1'b0;
        #1;
        expect_val("arst_pc", SEL_PC, 32'h0);
        expect_val("arst_wd", SEL_WD, 32'h0);
        drain();
        regwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        instr = 32'h00100033;
        @(posedge clk);
        #1;
        exp_pc = 32'd4;
        expect_val("post_rst_wd", SEL_WD, 32'h0);
        cycle(exp_pc + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
